// File: rtl/ram8_port_master_if.sv
// Host command, write/read streams and RAM8 pin bundle for ram8_port_master.
// master = the sequencer itself, slave = the host/RAM side around it.
interface ram8_port_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [2:0]  cmd_base;
    logic [2:0]  cmd_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic        busy;
    logic        done;
    logic [2:0]  ram_address;
    logic [15:0] ram_in;
    logic        ram_load;
    logic [15:0] ram_out;

    modport master (
        input  cmd_valid, cmd_write, cmd_base, cmd_len,
        input  wr_valid, wr_data, rd_ready, ram_out,
        output cmd_ready, wr_ready, rd_valid, rd_data,
        output busy, done, ram_address, ram_in, ram_load
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_base, cmd_len,
        output wr_valid, wr_data, rd_ready, ram_out,
        input  cmd_ready, wr_ready, rd_valid, rd_data,
        input  busy, done, ram_address, ram_in, ram_load
    );
endinterface

// File: rtl/ram8_port_master.sv
// Burst sequencer for the 8x16 RAM8: streams N words in (write) or out (read),
// with the address wrapping modulo 8.
module ram8_port_master (
    input  logic                  clk,
    input  logic                  rst_n,
    ram8_port_master_if.master    bus
);
    typedef enum logic [2:0] {IDLE, WR, RD, RD_DRAIN, FIN} state_t;

    state_t      state, state_nxt;
    logic [2:0]  addr, addr_nxt;
    logic [2:0]  remaining, remaining_nxt;
    logic [15:0] rd_data_q, rd_data_nxt;
    logic        rd_valid_q, rd_valid_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr       <= 3'd0;
            remaining  <= 3'd0;
            rd_data_q  <= 16'd0;
            rd_valid_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            addr       <= addr_nxt;
            remaining  <= remaining_nxt;
            rd_data_q  <= rd_data_nxt;
            rd_valid_q <= rd_valid_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        addr_nxt      = addr;
        remaining_nxt = remaining;
        rd_data_nxt   = rd_data_q;
        rd_valid_nxt  = rd_valid_q;
        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    addr_nxt      = bus.cmd_base;
                    remaining_nxt = bus.cmd_len;
                    state_nxt     = bus.cmd_write ? WR : RD;
                end
            end
            WR: begin
                if (bus.wr_valid) begin
                    addr_nxt = addr + 3'd1;
                    if (remaining == 3'd0) state_nxt = FIN;
                    else remaining_nxt = remaining - 3'd1;
                end
            end
            RD: begin
                // Fetch whenever the output register is empty or being drained.
                if (!rd_valid_q || bus.rd_ready) begin
                    rd_data_nxt  = bus.ram_out;
                    rd_valid_nxt = 1'b1;
                    addr_nxt     = addr + 3'd1;
                    if (remaining == 3'd0) state_nxt = RD_DRAIN;
                    else remaining_nxt = remaining - 3'd1;
                end
            end
            RD_DRAIN: begin
                if (bus.rd_ready) begin
                    rd_valid_nxt = 1'b0;
                    state_nxt    = FIN;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // RAM8 pins: address tracks addr directly, so it holds its last value in IDLE.
    assign bus.ram_address = addr;
    assign bus.ram_in      = bus.wr_data;
    assign bus.ram_load    = (state == WR) && bus.wr_valid;

    assign bus.cmd_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == FIN);
    assign bus.wr_ready  = (state == WR);
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
endmodule
